// File: rtl/axis_pattern_source.sv
// AXI4-Stream test-pattern source (counter / LFSR / constant) with a programmable
// tick divider, stall-drop counter and an AXI4-Lite register bank.
module axis_pattern_source #(
    parameter int RATE_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    output logic [31:0]           m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,

    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam logic [31:0] ADDR_CTRL  = 32'h0;
    localparam logic [31:0] ADDR_RATE  = 32'h4;
    localparam logic [31:0] ADDR_SEED  = 32'h8;
    localparam logic [31:0] ADDR_DROPS = 32'hC;

    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;

    logic                  run_q, run_d;
    logic [1:0]            mode_q, mode_d;
    logic [RATE_WIDTH-1:0] rate_q, rate_d;
    logic [RATE_WIDTH-1:0] div_q, div_d;
    logic [31:0]           seed_q, seed_d;
    logic [31:0]           drops_q, drops_d;
    logic [31:0]           gen_q, gen_d;
    logic [31:0]           tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  awready_q, awready_d;
    logic                  bvalid_q, bvalid_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [31:0] waddr;
    logic [31:0] raddr;
    logic        wr_en;
    logic        rd_en;
    logic        restart;
    logic        drops_clear;
    logic        load;
    logic [31:0] load_val;
    logic        tick;
    logic        slot_free;
    logic [31:0] gen_next;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

    always_comb begin
        waddr       = 32'(s_axi_awaddr);
        raddr       = 32'(s_axi_araddr);
        wr_en       = awready_q && s_axi_awvalid && s_axi_wvalid;
        rd_en       = arready_q && s_axi_arvalid;

        awready_d   = s_axi_awvalid && s_axi_wvalid && !bvalid_q && !awready_q;
        arready_d   = s_axi_arvalid && !rvalid_q && !arready_q;
        bvalid_d    = bvalid_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;

        run_d       = run_q;
        mode_d      = mode_q;
        rate_d      = rate_q;
        seed_d      = seed_q;
        restart     = 1'b0;
        drops_clear = 1'b0;

        if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
        if (wr_en) begin
            bvalid_d = 1'b1;
            case (waddr)
                ADDR_CTRL: begin
                    if (s_axi_wstrb[0]) begin
                        run_d   = s_axi_wdata[0];
                        mode_d  = s_axi_wdata[2:1];
                        restart = s_axi_wdata[3];
                    end
                end
                ADDR_RATE: begin
                    for (int i = 0; i < RATE_WIDTH; i++) begin
                        rate_d[i] = s_axi_wstrb[i/8] ? s_axi_wdata[i] : rate_q[i];
                    end
                end
                ADDR_SEED:  seed_d = merge_bytes(seed_q, s_axi_wdata, s_axi_wstrb);
                ADDR_DROPS: drops_clear = 1'b1;
                default: ;
            endcase
        end

        if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
        if (rd_en) begin
            rvalid_d = 1'b1;
            case (raddr)
                ADDR_CTRL:  rdata_d = {29'b0, mode_q, run_q};
                ADDR_RATE:  rdata_d = 32'(rate_q);
                ADDR_SEED:  rdata_d = seed_q;
                ADDR_DROPS: rdata_d = drops_q;
                default:    rdata_d = 32'h0;
            endcase
        end
    end

    // Generator: the SEED load (run rising or restart) overrides any advance in the same cycle.
    always_comb begin
        load      = restart || (run_d && !run_q);
        load_val  = (mode_d == MODE_LFSR && seed_d == 32'h0) ? 32'h1 : seed_d;
        tick      = run_q && (div_q == '0);
        slot_free = !tvalid_q || m_axis_tready;

        case (mode_q)
            MODE_LFSR:  gen_next = {gen_q[30:0], gen_q[31] ^ gen_q[21] ^ gen_q[1] ^ gen_q[0]};
            MODE_CONST: gen_next = gen_q;
            default:    gen_next = gen_q + 32'd1;
        endcase

        gen_d    = gen_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        drops_d  = drops_q;

        if (!run_q)    div_d = '0;
        else if (tick) div_d = rate_q;
        else           div_d = div_q - RATE_WIDTH'(1);

        if (tick) begin
            if (slot_free) begin
                tdata_d  = (mode_q == MODE_CONST) ? seed_q : gen_q;
                tvalid_d = 1'b1;
                gen_d    = gen_next;
            end else if (drops_q != 32'hFFFF_FFFF) begin
                drops_d = drops_q + 32'd1;
            end
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        if (load) begin
            gen_d = load_val;
            div_d = '0;
        end
        if (drops_clear) drops_d = 32'h0;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            run_q     <= 1'b0;
            mode_q    <= 2'd0;
            rate_q    <= '0;
            div_q     <= '0;
            seed_q    <= 32'h0;
            drops_q   <= 32'h0;
            gen_q     <= 32'h0;
            tdata_q   <= 32'h0;
            tvalid_q  <= 1'b0;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            run_q     <= run_d;
            mode_q    <= mode_d;
            rate_q    <= rate_d;
            div_q     <= div_d;
            seed_q    <= seed_d;
            drops_q   <= drops_d;
            gen_q     <= gen_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;

endmodule

// File: tb/tb_axis_pattern_source.sv
// Directed self-checking bench for axis_pattern_source: register access, pattern
// sequences, rate spacing, backpressure/drop counting, run clear, restart and reset.
module tb_axis_pattern_source;

    localparam logic [3:0] A_CTRL  = 4'h0;
    localparam logic [3:0] A_RATE  = 4'h4;
    localparam logic [3:0] A_SEED  = 4'h8;
    localparam logic [3:0] A_DROPS = 4'hC;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready = 1'b1;
    logic [3:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [3:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;

    int checkCount = 0;
    int passCount  = 0;

    axis_pattern_source #(.RATE_WIDTH(16), .ADDR_WIDTH(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    endtask

    // Called on a negedge; returns on the negedge right after the handshake edge.
    task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin
            @(posedge aclk); #1; n++;
        end while (!(awready && wready) && n < 20);
        checkOutput("aw_w_ready", {31'b0, awready && wready}, 32'd1);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        checkOutput("bvalid_bresp", {29'b0, bvalid, bresp}, 32'h4);
        @(negedge aclk);
    endtask

    task automatic axiRead(input logic [3:0] addr, output logic [31:0] data);
        int n;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        do begin
            @(posedge aclk); #1; n++;
        end while (!arready && n < 20);
        checkOutput("arready", {31'b0, arready}, 32'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        checkOutput("rvalid_rresp", {29'b0, rvalid, rresp}, 32'h4);
        data = rdata;
        @(negedge aclk);
    endtask

    task automatic readCheck(input string tag, input logic [3:0] addr, input logic [31:0] expected);
        logic [31:0] d;
        axiRead(addr, d);
        checkOutput(tag, d, expected);
    endtask

    // Program SEED and RATE, then CTRL last so the run edge is the final handshake.
    task automatic applyStimulus(input logic [31:0] seed, input logic [31:0] rate, input logic [31:0] ctrl);
        axiWrite(A_SEED, seed, 4'hF);
        axiWrite(A_RATE, rate, 4'hF);
        axiWrite(A_CTRL, ctrl, 4'hF);
        checkOutput("first_gap_tvalid", {31'b0, tvalid}, 32'd0);
        @(negedge aclk);
        checkOutput("first_tvalid", {31'b0, tvalid}, 32'd1);
        checkOutput("first_tdata", tdata, seed == 32'h0 && ctrl[2:1] == 2'd1 ? 32'h1 : seed);
    endtask

    task automatic stopRun();
        axiWrite(A_CTRL, 32'h0, 4'hF);
        @(negedge aclk);
        checkOutput("stop_tvalid", {31'b0, tvalid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] lfsrExp [4];
        lfsrExp[0] = 32'd1; lfsrExp[1] = 32'd3; lfsrExp[2] = 32'd6; lfsrExp[3] = 32'd13;

        $display("[TB] reset state");
        repeat (3) @(negedge aclk);
        checkOutput("rst_tvalid", {31'b0, tvalid}, 32'd0);
        checkOutput("rst_tdata", tdata, 32'd0);
        checkOutput("rst_axi_hs", {27'b0, awready, wready, bvalid, arready, rvalid}, 32'd0);
        checkOutput("rst_rdata_resp", {rdata[27:0], bresp, rresp}, 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        readCheck("rst_ctrl", A_CTRL, 32'h0);
        readCheck("rst_rate", A_RATE, 32'h0);
        readCheck("rst_seed", A_SEED, 32'h0);
        readCheck("rst_drops", A_DROPS, 32'h0);

        $display("[TB] byte strobes");
        axiWrite(A_SEED, 32'hAABBCCDD, 4'hF);
        axiWrite(A_SEED, 32'h11223344, 4'b0101);
        readCheck("seed_wstrb", A_SEED, 32'hAA22CC44);
        axiWrite(A_RATE, 32'h12345678, 4'b0010);
        readCheck("rate_wstrb", A_RATE, 32'h00005600);

        $display("[TB] counter, RATE=0");
        applyStimulus(32'd5, 32'd0, 32'h1);
        for (int i = 1; i < 4; i++) begin
            @(negedge aclk);
            checkOutput("cnt_tvalid", {31'b0, tvalid}, 32'd1);
            checkOutput("cnt_tdata", tdata, 32'd5 + 32'(i));
        end
        stopRun();
        readCheck("cnt_drops", A_DROPS, 32'h0);

        $display("[TB] counter, RATE=3");
        applyStimulus(32'd100, 32'd3, 32'h1);
        for (int i = 1; i < 13; i++) begin
            @(negedge aclk);
            checkOutput("rate3_tvalid", {31'b0, tvalid}, (i % 4 == 0) ? 32'd1 : 32'd0);
            if (i % 4 == 0) checkOutput("rate3_tdata", tdata, 32'd100 + 32'(i / 4));
        end
        stopRun();
        readCheck("rate3_drops", A_DROPS, 32'h0);

        $display("[TB] backpressure");
        applyStimulus(32'h20, 32'd0, 32'h1);
        tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            checkOutput("stall_tvalid", {31'b0, tvalid}, 32'd1);
            checkOutput("stall_tdata", tdata, 32'h20);
        end
        tready = 1'b1;
        @(negedge aclk);
        checkOutput("after_stall_1", tdata, 32'h21);
        @(negedge aclk);
        checkOutput("after_stall_2", tdata, 32'h22);
        stopRun();
        readCheck("stall_drops", A_DROPS, 32'd10);
        axiWrite(A_DROPS, 32'h5, 4'hF);
        readCheck("drops_clear", A_DROPS, 32'h0);

        $display("[TB] LFSR");
        applyStimulus(32'd1, 32'd0, 32'h3);
        for (int i = 1; i < 4; i++) begin
            @(negedge aclk);
            checkOutput("lfsr_tdata", tdata, lfsrExp[i]);
        end
        stopRun();
        applyStimulus(32'd0, 32'd0, 32'h3);
        stopRun();

        $display("[TB] constant, run cleared during stall");
        applyStimulus(32'hDEADBEEF, 32'd0, 32'h5);
        tready = 1'b0;
        axiWrite(A_CTRL, 32'h4, 4'hF);
        @(negedge aclk);
        checkOutput("const_hold_tvalid", {31'b0, tvalid}, 32'd1);
        checkOutput("const_hold_tdata", tdata, 32'hDEADBEEF);
        tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            checkOutput("const_idle_tvalid", {31'b0, tvalid}, 32'd0);
        end
        readCheck("const_ctrl", A_CTRL, 32'h4);
        axiWrite(A_DROPS, 32'hFFFFFFFF, 4'hF);
        readCheck("const_drops_clear", A_DROPS, 32'h0);

        $display("[TB] restart during stall");
        applyStimulus(32'h50, 32'd0, 32'h1);
        tready = 1'b0;
        axiWrite(A_CTRL, 32'h9, 4'hF);
        checkOutput("restart_hold_tvalid", {31'b0, tvalid}, 32'd1);
        checkOutput("restart_hold_tdata", tdata, 32'h50);
        tready = 1'b1;
        @(negedge aclk);
        checkOutput("restart_next_1", tdata, 32'h50);
        @(negedge aclk);
        checkOutput("restart_next_2", tdata, 32'h51);
        readCheck("restart_ctrl_reads", A_CTRL, 32'h1);
        stopRun();

        $display("[TB] reset mid-stream");
        applyStimulus(32'd7, 32'd0, 32'h1);
        @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        checkOutput("midrst_tvalid", {31'b0, tvalid}, 32'd0);
        checkOutput("midrst_tdata", tdata, 32'd0);
        aresetn = 1'b1;
        readCheck("midrst_ctrl", A_CTRL, 32'h0);
        readCheck("midrst_rate", A_RATE, 32'h0);
        readCheck("midrst_seed", A_SEED, 32'h0);
        readCheck("midrst_drops", A_DROPS, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            checkOutput("midrst_idle", {31'b0, tvalid}, 32'd0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/axis_pattern_source.md
# axis_pattern_source

- Programmable AXI4-Stream test-pattern source feeding one input of the dual-input stream packet mux, which frames it for AXI DMA.
- Emits unframed 32-bit beats (no TLAST/TKEEP) from a counter, LFSR or constant generator, at a rate set by a programmable divider.
- Honours backpressure and counts generator ticks lost while a beat is stalled.
- Configured over AXI4-Lite.

## Interface
- RATE_WIDTH, 16, width of the rate divider register
- ADDR_WIDTH, 4, AXI4-Lite address width (>=4)

Ports:
- aclk  in  1  clock; reset aresetn is synchronous, active-low
- aresetn  in  1  synchronous active-low reset
- m_axis_tdata  out  32  pattern beat
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data

## Operation
Registers (word-aligned; wstrb honoured per byte):
- 0x00 CTRL:
  - [0] run (R/W)
  - [2:1] mode (R/W): 0 counter, 1 LFSR, 2 constant, 3 treated as counter
  - [3] restart (write-1 pulse, reads 0)
- 0x04 RATE [RATE_WIDTH-1:0] (R/W): one tick every RATE+1 cycles.
- 0x08 SEED [31:0] (R/W): start value for counter/LFSR; output value in constant mode.
- 0x0C DROPS [31:0] (RO): saturating count of lost ticks. Any write clears it.

Unmapped reads return 0; unmapped writes are ignored; all responses OKAY.

Divider and tick:
- run=0: divider held at 0; no ticks.
- run=1: tick when divider==0, then reload RATE; otherwise decrement.

Generator state `gen`:
- Loaded with SEED on the run 0->1 edge or a restart pulse; the divider is zeroed at the same time. In LFSR mode, SEED==0 loads 1.
- Next value:
  - counter: gen+1 mod 2^32.
  - LFSR: {gen[30:0], gen[31]^gen[21]^gen[1]^gen[0]}.
  - constant: gen unchanged; tdata = SEED.

Tick handling:
- Slot free (tvalid=0, or tvalid&&tready): tdata<=gen (constant mode: SEED), tvalid<=1, gen advances.
- Slot stalled (tvalid&&!tready): DROPS increments (saturates at 0xFFFFFFFF), gen does not advance.

No tick:
- tvalid&&tready: tvalid<=0.
- Otherwise hold.

AXI-Stream rules:
- tdata is stable while tvalid&&!tready.
- Clearing run or restarting never withdraws a pending beat; it is held until accepted, and no further beats are issued while run=0.
- A restart during a stall keeps the pending beat; the next beat is SEED.

## Timing
Reset values:
- Outputs: all 0 (awready, wready, bvalid, arready, rvalid, tvalid, tdata, rdata, bresp, rresp).
- Registers: CTRL, RATE, SEED, DROPS, gen, divider all 0.

AXI4-Lite write:
- Accepted when awvalid&&wvalid&&!bvalid.
- awready and wready pulse together for 1 cycle.
- Register updated and bvalid raised on the next edge; bvalid held until bready.

AXI4-Lite read:
- arready pulses 1 cycle when arvalid&&!rvalid.
- rdata/rvalid registered the next cycle and held until rready.

Stream timing:
- Write handshake that sets run at cycle N: run=1 at N+1, first tick at N+1, tvalid=1 at N+2.
- With tready=1, beats are spaced exactly RATE+1 cycles; RATE=0 gives one beat per cycle, tvalid continuously high.
- Tick coinciding with a handshake: the new beat is presented the next cycle with no gap.
- aresetn low mid-stream: tvalid=0 on the next edge; all state returns to reset values.

## Test plan
- Counter, SEED=5, RATE=0, tready=1, run=1 -> tdata 5,6,7,8… on consecutive cycles; first tvalid two cycles after the write handshake.
- RATE=3, tready=1 -> tvalid high 1 cycle in 4; values consecutive; DROPS=0.
- RATE=0, tready low for 10 cycles while tvalid=1 -> tdata stable throughout; DROPS=10; next beat follows the held value with no skipped values.
- LFSR, SEED=1 -> 1,3,6,13; LFSR with SEED=0 -> first beat 1.
- Constant, SEED=0xDEADBEEF, clear run during a stall -> held beat accepted once tready rises, then tvalid stays 0; a write to DROPS reads back 0.
- aresetn low for 1 cycle mid-stream at RATE=0 -> tvalid=0, all registers read 0, no beats until run is rewritten.
